// File: rtl/seg7_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg7_scan_pkg;

    // Active-low segment patterns, bit 7 is dp (kept off), bits 6:0 are g..a.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned IDX_W  = 2;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Prescaler length in clk cycles per displayed digit.
    function automatic int unsigned scan_div(input int unsigned clk_hz,
                                             input int unsigned scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low segment pattern; non-BCD shows a dash.
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] pattern_c
);

    // Pattern lookup, blank overrides everything.
    always_comb begin
        pattern_c = SEG_DASH;
        if (blank) begin
            pattern_c = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    pattern_c = SEG_0;
                4'd1:    pattern_c = SEG_1;
                4'd2:    pattern_c = SEG_2;
                4'd3:    pattern_c = SEG_3;
                4'd4:    pattern_c = SEG_4;
                4'd5:    pattern_c = SEG_5;
                4'd6:    pattern_c = SEG_6;
                4'd7:    pattern_c = SEG_7;
                4'd8:    pattern_c = SEG_8;
                4'd9:    pattern_c = SEG_9;
                default: pattern_c = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-coherent shadow
// register, anti-ghost blanking and optional leading-zero suppression.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned DIV    = scan_div(CLK_HZ, SCAN_HZ);
    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BCNT_W = $clog2(BLANK_CYC + 2);

    // Blanking must finish before the next digit change.
    generate
        if (DIV < BLANK_CYC + 2) begin : g_div_check
            $error("seg7_scan: CLK_HZ/SCAN_HZ must be at least BLANK_CYC+2");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt;
    logic [BCNT_W-1:0] bcnt;
    digit_idx_t        idx;
    logic [15:0]       shadow;
    logic              valid;

    logic              tick_c;
    logic [3:0]        nib_c;
    logic              blank_c;
    logic [7:0]        pattern_c;
    logic [3:0]        an_c;
    logic [7:0]        seg_c;

    // One-cycle strobe at the last prescaler count.
    always_comb begin
        tick_c = (cnt == CNT_W'(DIV - 1));
    end

    // Prescaler: 0..DIV-1, wraps on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Digit index advances once per tick; frame is captured when leaving digit 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            shadow <= '0;
            valid  <= 1'b0;
        end else if (tick_c) begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(DIGITS - 1)) begin
                shadow <= data;
                valid  <= 1'b1;
            end
        end
    end

    // Anti-ghost counter: loaded on each digit change, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
        end else if (tick_c) begin
            bcnt <= BCNT_W'(BLANK_CYC);
        end else if (bcnt != '0) begin
            bcnt <= bcnt - BCNT_W'(1);
        end
    end

    // Select the nibble and blanking condition for the current digit.
    always_comb begin
        nib_c   = shadow[3:0];
        blank_c = !valid;
        case (idx)
            2'd0: nib_c = shadow[3:0];
            2'd1: begin
                nib_c = shadow[7:4];
                if (blank_lz && (shadow[7:4] == 4'd0)) blank_c = 1'b1;
            end
            2'd2: nib_c = shadow[11:8];
            2'd3: begin
                nib_c = shadow[15:12];
                if (blank_lz && (shadow[15:12] == 4'd0)) blank_c = 1'b1;
            end
            default: nib_c = shadow[3:0];
        endcase
    end

    seg7_decode u_decode (
        .nibble    (nib_c),
        .blank     (blank_c),
        .pattern_c (pattern_c)
    );

    // Next output values: all off during blanking, otherwise one digit lit.
    always_comb begin
        an_c  = 4'b1111;
        seg_c = SEG_BLANK;
        if (bcnt == '0) begin
            an_c  = ~(4'b0001 << idx);
            seg_c = pattern_c;
        end
    end

    // Registered outputs, forced off asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_c;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIV=4, BLANK_CYC=1.
module tb_seg7_scan;

    localparam int unsigned CLK_HZ    = 16;
    localparam int unsigned SCAN_HZ   = 4;
    localparam int unsigned BLANK_CYC = 1;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] data     = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .CLK_HZ    (CLK_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    // Advance one clock; outputs are then stable until the next posedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Reset hold and the first scan pass before any frame is captured.
    task automatic test_reset();
        logic [3:0] onehot;
        logic [3:0] exp_an;
        data     = 16'h2010;
        blank_lz = 1'b0;
        rst_n    = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_hold: an=%b seg=%h, want an=1111 seg=ff", an, seg);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            onehot = 4'b0001 << ((k - 1) / 4);
            exp_an = (k > 4 && (k - 1) % 4 == 0) ? 4'b1111 : ~onehot;
            vectors++;
            if (an !== exp_an || seg !== 8'hFF) begin
                errors++;
                $display("FAIL first_pass k=%0d: an=%b seg=%h, want an=%b seg=ff",
                         k, an, seg, exp_an);
            end
        end
    endtask

    // Steady 2010 without blanking: four digits, one off cycle each.
    task automatic test_scan();
        logic [7:0] tab [4];
        logic [3:0] onehot;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        tab[0] = 8'hC0; tab[1] = 8'hF9; tab[2] = 8'hC0; tab[3] = 8'hA4;
        for (int j = 0; j < 16; j++) begin
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL scan_2010 j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    // Leading-zero suppression on both pairs, then the same frame unsuppressed.
    task automatic test_blank_lz();
        logic [7:0] tab [4];
        logic [3:0] onehot;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        data     = 16'h0509;
        blank_lz = 1'b1;
        repeat (16) cyc();
        // Both tens digits are zero, so digits 1 and 3 go dark with an still low.
        tab[0] = 8'h90; tab[1] = 8'hFF; tab[2] = 8'h92; tab[3] = 8'hFF;
        for (int j = 0; j < 16; j++) begin
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL blank_lz_on j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
        blank_lz = 1'b0;
        tab[0] = 8'h90; tab[1] = 8'hC0; tab[2] = 8'h92; tab[3] = 8'hC0;
        for (int j = 0; j < 16; j++) begin
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL blank_lz_off j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    // Remaining decode entries, then non-BCD dashes in the following frame.
    task automatic test_decode();
        logic [7:0] tab [4];
        logic [3:0] onehot;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        data = 16'h3467;
        repeat (16) cyc();
        data = 16'hFA00;
        tab[0] = 8'hF8; tab[1] = 8'h82; tab[2] = 8'h99; tab[3] = 8'hB0;
        for (int j = 0; j < 16; j++) begin
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL decode_3467 j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
        tab[0] = 8'hC0; tab[1] = 8'hC0; tab[2] = 8'hBF; tab[3] = 8'hBF;
        for (int j = 0; j < 16; j++) begin
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL dash_fa00 j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    // data changes while digit 1 is shown; old value holds to the frame end.
    task automatic test_midframe();
        logic [7:0] tab [4];
        logic [3:0] onehot;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        data = 16'h1919;
        repeat (16) cyc();
        tab[0] = 8'h90; tab[1] = 8'hF9; tab[2] = 8'h90; tab[3] = 8'hF9;
        for (int j = 0; j < 16; j++) begin
            if (j == 5) data = 16'h1818;
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL midframe_old j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
        tab[0] = 8'h80; tab[1] = 8'hF9; tab[2] = 8'h80; tab[3] = 8'hF9;
        for (int j = 0; j < 16; j++) begin
            cyc();
            onehot  = 4'b0001 << (j / 4);
            exp_an  = (j % 4 == 0) ? 4'b1111 : ~onehot;
            exp_seg = (j % 4 == 0) ? 8'hFF : tab[j / 4];
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL midframe_new j=%0d: an=%b seg=%h, want an=%b seg=%h",
                         j, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    // One-clock reset pulse while digit 2 is lit; scan restarts blank at digit 0.
    task automatic test_reset_midframe();
        logic [3:0] onehot;
        logic [3:0] exp_an;
        repeat (10) cyc();
        vectors++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_digit: an=%b, want an=1011", an);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++;
            $display("FAIL async_off: an=%b seg=%h, want an=1111 seg=ff", an, seg);
        end
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            onehot = 4'b0001 << ((k - 1) / 4);
            exp_an = (k > 4 && (k - 1) % 4 == 0) ? 4'b1111 : ~onehot;
            vectors++;
            if (an !== exp_an || seg !== 8'hFF) begin
                errors++;
                $display("FAIL restart k=%0d: an=%b seg=%h, want an=%b seg=ff",
                         k, an, seg, exp_an);
            end
        end
        repeat (2) cyc();
        vectors++;
        if (an !== 4'b1110 || seg !== 8'h80) begin
            errors++;
            $display("FAIL restart_frame: an=%b seg=%h, want an=1110 seg=80", an, seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_lz();
        test_decode();
        test_midframe();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

endmodule
